regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between NUM_REQ writeback requesters, e.g. requester 0 = ALU writeback, requester 1 = memory-load writeback.
- Each requester gets a small FIFO with a valid/ready handshake.
- A round-robin arbiter drains the FIFOs, issuing at most one register write per cycle.
- Exports a pending-write scoreboard so the controller can stall reads of registers with queued writes.

Parameters:
- NUM_REQ, 2, number of writeback requesters (2..4).
- DEPTH, 2, entries per requester FIFO (power of two, 2..8).

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester write request valid.
- req_addr  in  NUM_REQ*5  per-requester destination register; requester i occupies bits [5i+4:5i].
- req_data  in  NUM_REQ*32  per-requester write data; requester i occupies bits [32i+31:32i].
- req_ready  out  NUM_REQ  per-requester FIFO can accept.
- hold  in  1  when high, no writes are issued; FIFOs still accept.
- rf_en_write  out  1  write enable to the register file.
- rf_addr_write  out  5  write address to the register file.
- rf_data_write  out  32  write data to the register file.
- pending  out  32  bit r is high while any FIFO holds an entry for register r.
- idle  out  1  all FIFOs empty.

Behaviour:
- Reset (synchronous, active-high):
  - All FIFOs empty; round-robin pointer last_grant = NUM_REQ-1.
  - While reset is high: req_ready = 0, rf_en_write = 0, pending = 0, idle = 1.
  - rf_addr_write and rf_data_write are 0 whenever rf_en_write = 0.
  - Reset asserted mid-operation discards all queued writes. No write is issued in the reset cycle.
- Enqueue:
  - Accept on requester i when req_valid[i] && req_ready[i] at a rising edge.
  - req_ready[i] = !full_i, taken from registered occupancy only. There is no combinational path from valid or hold to ready.
  - A full FIFO deasserts ready even if it dequeues in the same cycle; there is no pass-through.
  - req_valid while !ready is ignored. The requester must hold its data until accepted.
- Arbitration (combinational, each cycle):
  - Candidates are the non-empty FIFOs.
  - Priority order is last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - The first non-empty FIFO in that order wins. rf_en_write = 1 and rf_addr_write/rf_data_write = that FIFO's head.
  - If hold = 1 or all FIFOs are empty: rf_en_write = 0 and last_grant is unchanged.
- Dequeue:
  - At the edge ending a cycle with rf_en_write = 1, the winner's head pops (the regfile captures the same write at that edge) and last_grant takes the winner's index.
- Latency: accepted at edge N -> earliest visible on the rf_* outputs in cycle N+1 -> regfile updated at edge N+1.
- Ordering:
  - Within one requester, writes complete in FIFO order.
  - Across requesters, same-address writes complete in grant order; no cross-requester address ordering is enforced.
- Simultaneous enqueue and dequeue on the same non-full FIFO: occupancy is unchanged and both take effect.
- pending:
  - Combinational OR over all valid FIFO entries of a one-hot decode of their address.
  - An entry's bit clears in the cycle after its write edge, unless another queued entry targets the same register.
- Register 0 is an ordinary register here; writes to address 0 are forwarded unchanged.
- Wrap-around: FIFO read/write pointers are log2(DEPTH) bits wide plus one extra bit for full/empty disambiguation.

Decomposition:
- Shared include file (constants): REG_ADDR_W = 5, REG_DATA_W = 32, NUM_REGS = 32, with the same write-entry layout {addr, data} used by the regfile interface.
- One sub-module, wb_queue:
  - Parameterised synchronous FIFO with DEPTH entries of REG_ADDR_W+REG_DATA_W bits.
  - Ports: push, pop, full, empty, head, and a per-entry valid/addr vector for the pending decode.
  - Instantiated NUM_REQ times.
- Arbiter and pending decode stay in the top level.

Test Plan:
- Reset, then a single request:
  - Stimulus: reset high 2 cycles -> req_ready = 0 and idle = 1 throughout; release, then req0 addr 5, data 0xDEADBEEF.
  - Response: rf_en_write = 1 with addr 5, data 0xDEADBEEF in the next cycle; pending[5] high exactly 1 cycle; idle returns to 1.
- Round-robin:
  - Stimulus: both requesters push 2 entries in the same cycles (req0 addr 1,2; req1 addr 3,4).
  - Response: write order 1, 3, 2, 4 on consecutive cycles.
- Full / backpressure:
  - Stimulus: hold = 1 and req0 pushes 3 back-to-back.
  - Response: req_ready[0] drops after the 2nd accept and the 3rd is stalled; release hold -> writes issue on 2 consecutive cycles and ready reasserts after the first pop.
- Same address from both requesters:
  - Stimulus: req0 and req1 both target addr 7.
  - Response: pending[7] stays high until both writes are issued, then clears.
- Reset mid-operation:
  - Stimulus: 3 entries queued, then reset for 1 cycle.
  - Response: no rf_en_write in or after reset; pending = 0, idle = 1.
- Hold plus concurrent push/pop:
  - Stimulus: hold toggled every cycle while req1 streams 6 writes.
  - Response: all 6 written in order, none duplicated or dropped, and rf_en_write never high while hold = 1.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and the {addr, data} write-entry layout used by the
// writeback queues and the register-file write port.
package regfile_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_write_arbiter_wb_queue.sv
// Per-requester writeback FIFO; exposes every slot's valid flag and address
// so the top level can build the pending-write scoreboard.
module wb_queue
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             push,
  input  logic                             pop,
  input  wb_entry_t                        push_entry,
  output logic                             full,
  output logic                             empty,
  output wb_entry_t                        head,
  output logic [DEPTH-1:0]                 ent_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_addr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;
  logic [AW:0]            count;
  logic [DEPTH-1:0][AW-1:0] offset;
  wb_entry_t              mem [DEPTH];

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  // A slot is live when its distance from the read pointer is below occupancy.
  always_comb begin
    offset    = '0;
    ent_valid = '0;
    ent_addr  = '0;
    for (int j = 0; j < DEPTH; j++) begin
      offset[j]    = AW'(j) - rd_ptr[AW-1:0];
      ent_valid[j] = ({1'b0, offset[j]} < count);
      ent_addr[j]  = mem[j].addr;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between
// NUM_REQ queued writeback requesters, with a pending-write scoreboard.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DEPTH   = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*REG_DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic                             hold,
  output logic                             rf_en_write,
  output logic [REG_ADDR_W-1:0]            rf_addr_write,
  output logic [REG_DATA_W-1:0]            rf_data_write,
  output logic [NUM_REGS-1:0]              pending,
  output logic                             idle
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [GW-1:0] LAST_INIT = GW'(NUM_REQ - 1);

  logic [GW-1:0]                                    last_grant;
  logic [GW-1:0]                                    win;
  logic                                             found;
  int                                               cand;
  logic [NUM_REQ-1:0]                               q_full;
  logic [NUM_REQ-1:0]                               q_empty;
  wb_entry_t [NUM_REQ-1:0]                          q_head;
  wb_entry_t [NUM_REQ-1:0]                          q_in;
  logic [NUM_REQ-1:0][DEPTH-1:0]                    q_valid;
  logic [NUM_REQ-1:0][DEPTH-1:0][REG_ADDR_W-1:0]    q_addr;
  logic [NUM_REGS-1:0]                              pend_raw;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_q
    assign q_in[gi].addr = req_addr[REG_ADDR_W*gi +: REG_ADDR_W];
    assign q_in[gi].data = req_data[REG_DATA_W*gi +: REG_DATA_W];
    // Ready depends only on registered occupancy, never on valid or hold.
    assign req_ready[gi] = !reset && !q_full[gi];

    wb_queue #(.DEPTH(DEPTH)) u_queue (
      .clock      (clock),
      .reset      (reset),
      .push       (req_valid[gi] && req_ready[gi]),
      .pop        (rf_en_write && (win == GW'(gi))),
      .push_entry (q_in[gi]),
      .full       (q_full[gi]),
      .empty      (q_empty[gi]),
      .head       (q_head[gi]),
      .ent_valid  (q_valid[gi]),
      .ent_addr   (q_addr[gi])
    );
  end

  // Search from last_grant+1 upward, wrapping, for the first non-empty queue.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && !q_empty[cand]) begin
        found = 1'b1;
        win   = GW'(cand);
      end
    end
  end

  assign rf_en_write   = found && !hold && !reset;
  assign rf_addr_write = rf_en_write ? q_head[win].addr : '0;
  assign rf_data_write = rf_en_write ? q_head[win].data : '0;

  always_ff @(posedge clock) begin
    if (reset)            last_grant <= LAST_INIT;
    else if (rf_en_write) last_grant <= win;
  end

  always_comb begin
    pend_raw = '0;
    for (int i = 0; i < NUM_REQ; i++)
      for (int j = 0; j < DEPTH; j++)
        if (q_valid[i][j]) pend_raw[q_addr[i][j]] = 1'b1;
  end

  assign pending = reset ? '0 : pend_raw;
  assign idle    = reset || (&q_empty);

endmodule
